debug_tx_sequencer: RTL and testbench
=====================================

DEBUG_TX_SEQUENCER -- requirements
Module: debug_tx_sequencer

Interface
REQ-001 The block SHALL take parameter NUM_BYTES, default 220, meaning the number of frame bytes to transmit.
REQ-002 The block SHALL take parameter FRAME_W, default 1760, meaning the frame width in bits, fixed at NUM_BYTES*8.
REQ-003 Port: clock, input, 1, the single clock; every register is updated on its rising edge.
REQ-004 Port: reset, input, 1, asynchronous active-high reset.
REQ-005 Port: sendSignal, input, 1, single-cycle request to transmit the frame.
REQ-006 Port: sendData, input, FRAME_W, frame contents; byte k is sendData[8k+7:8k].
REQ-007 Port: tx_full, input, 1, UART transmit FIFO is full.
REQ-008 Port: w_data, output, 8, byte presented to the UART transmit FIFO.
REQ-009 Port: wr_uart, output, 1, write strobe to the UART transmit FIFO.
REQ-010 Port: busy, output, 1, a frame is in progress.
REQ-011 Port: done, output, 1, one-cycle pulse at the end of a frame.
REQ-012 Port: dropped, output, 1, one-cycle pulse when a request is rejected.

Function
REQ-013 The state machine SHALL have the states IDLE, HEADER, SEND and DONE.
REQ-014 In IDLE with sendSignal=1, the block SHALL latch sendData into a FRAME_W shift register, clear the byte counter and move to HEADER (macro defined) or SEND (macro undefined).
REQ-015 In HEADER, when tx_full=0, wr_uart SHALL be 1 and w_data SHALL be 8'hA5 in that cycle, and the next state SHALL be SEND.
REQ-016 In SEND, wr_uart SHALL equal !tx_full, combinationally in the same cycle, and w_data SHALL equal shift register bits [7:0].
REQ-017 Each cycle with wr_uart=1 in SEND SHALL shift the register right by 8 and increment the counter, so bytes leave in order byte 0 first.
REQ-018 A write in SEND while counter==NUM_BYTES-1 SHALL move the machine to DONE.
REQ-019 A HEADER or SEND cycle with tx_full=1 SHALL stall: no write, and state, counter and register unchanged, for an unlimited number of cycles.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle and the next state SHALL be IDLE.
REQ-021 busy SHALL be 1 in HEADER, SEND and DONE, and 0 in IDLE.
REQ-022 sendSignal=1 while the state is not IDLE SHALL drive dropped=1 in that same cycle and SHALL leave the frame in progress unchanged.
REQ-023 Latency without back-pressure, macro undefined: sendSignal at cycle 0 gives bytes at cycles 1..NUM_BYTES, done at cycle NUM_BYTES+1, and the next request is accepted at cycle NUM_BYTES+2.
REQ-024 The counter SHALL be 8 bits and SHALL never wrap, because NUM_BYTES is at most 255.
REQ-025 sendData SHALL be sampled only on the accepting cycle; later changes to it SHALL have no effect.
REQ-026 Outside HEADER and SEND, wr_uart SHALL be 0 and w_data SHALL be 8'h00.

Reset
REQ-027 Asserting reset SHALL immediately force state IDLE, counter 0, shift register 0, and busy, done, dropped and wr_uart to 0.
REQ-028 Reset during HEADER or SEND SHALL abort the frame; it SHALL NOT resume, and no done pulse SHALL be produced.

Configuration
REQ-029 With DEBUG_TX_HEADER_EN defined, the block SHALL send the sync byte 8'hA5 before byte 0, and every latency SHALL be one cycle longer.
REQ-030 With DEBUG_TX_HEADER_EN undefined, the HEADER state SHALL be absent and IDLE SHALL go directly to SEND.

Structure
REQ-031 The shared package debug_pkg SHALL hold the NUM_BYTES default, the HEADER_BYTE constant 8'hA5 and the state enum type.
REQ-032 The block SHALL be a single module with no sub-module, since the shift register, counter and state machine are small.

Verification
REQ-033 Reset, then tx_full=0 and sendSignal with byte k = k+1, macro off: wr_uart is high for cycles 1..220, w_data runs 1,2,...,220 (8'hDC), done pulses at cycle 221 and busy falls at cycle 222.
REQ-034 Same stimulus with DEBUG_TX_HEADER_EN defined: first byte 8'hA5 at cycle 1, data bytes at cycles 2..221, done at cycle 222.
REQ-035 Drive tx_full=1 for 5 cycles after byte 10 has been written: no wr_uart during the stall, byte 11 follows the stall with no byte lost or repeated, and done is delayed by exactly 5 cycles.
REQ-036 Pulse sendSignal at cycle 50 of a frame: dropped=1 at cycle 50, and the output stream and done timing are identical to REQ-033.
REQ-037 Assert reset at cycle 100 of a frame: outputs go to 0 without waiting for a clock edge; after release, no further writes occur until a new sendSignal, and a fresh frame then completes normally.
REQ-038 Change sendData every cycle during a frame: every transmitted byte matches the value captured at acceptance.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and constants for the debug UART frame sequencer.
// DEBUG_TX_HEADER_EN adds the HEADER state used to emit the sync byte.
package debug_pkg;

  localparam int         NUM_BYTES_DEFAULT = 220;
  localparam logic [7:0] HEADER_BYTE       = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    DONE   = 2'd2
`ifdef DEBUG_TX_HEADER_EN
    ,
    HEADER = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/debug_tx_sequencer.sv
// Streams a latched frame byte-by-byte into a UART TX FIFO, honouring tx_full back-pressure.
// Define DEBUG_TX_HEADER_EN to prefix each frame with the HEADER_BYTE sync byte.
module debug_tx_sequencer
  import debug_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEFAULT,
  parameter int FRAME_W   = NUM_BYTES * 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sendSignal,
  input  logic [FRAME_W-1:0] sendData,
  input  logic               tx_full,
  output logic [7:0]         w_data,
  output logic               wr_uart,
  output logic               busy,
  output logic               done,
  output logic               dropped
);

  state_t             r_state;
  logic [FRAME_W-1:0] r_shift;
  logic [7:0]         r_count;

  state_t             w_state_nxt;
  logic [FRAME_W-1:0] w_shift_nxt;
  logic [7:0]         w_count_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Outputs depend on the live tx_full so a full FIFO blocks the write in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_count_nxt = r_count;
    w_data      = 8'h00;
    wr_uart     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    dropped     = 1'b0;

    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (sendSignal) begin
          w_shift_nxt = sendData;
          w_count_nxt = 8'd0;
`ifdef DEBUG_TX_HEADER_EN
          w_state_nxt = HEADER;
`else
          w_state_nxt = SEND;
`endif
        end
      end
`ifdef DEBUG_TX_HEADER_EN
      HEADER: begin
        dropped = sendSignal;
        if (!tx_full) begin
          wr_uart     = 1'b1;
          w_data      = HEADER_BYTE;
          w_state_nxt = SEND;
        end
      end
`endif
      SEND: begin
        dropped = sendSignal;
        wr_uart = !tx_full;
        w_data  = r_shift[7:0];
        if (!tx_full) begin
          w_shift_nxt = {8'h00, r_shift[FRAME_W-1:8]};
          w_count_nxt = r_count + 8'd1;
          if (r_count == 8'(NUM_BYTES - 1)) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        dropped     = sendSignal;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// Directed bench for debug_tx_sequencer: full frames, stall, dropped request, async reset, late data changes.
// Follows DEBUG_TX_HEADER_EN to expect the sync byte when the header is built in.
module tb_debug_tx_sequencer;
  import debug_pkg::*;

  localparam int NB = 220;
  localparam int FW = NB * 8;
`ifdef DEBUG_TX_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          sendSignal;
  logic          tx_full;
  logic [FW-1:0] sendData;
  logic [7:0]    w_data;
  logic          wr_uart;
  logic          busy;
  logic          done;
  logic          dropped;

  int            checkCount = 0;
  int            failCount  = 0;
  logic [FW-1:0] expFrame;

  always #5 clock = ~clock;

  debug_tx_sequencer #(
    .NUM_BYTES(NB),
    .FRAME_W  (FW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sendSignal(sendSignal),
    .sendData  (sendData),
    .tx_full   (tx_full),
    .w_data    (w_data),
    .wr_uart   (wr_uart),
    .busy      (busy),
    .done      (done),
    .dropped   (dropped)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] packOut();
    return {20'd0, busy, done, dropped, wr_uart, w_data};
  endfunction

  function automatic logic [31:0] expOut(input logic b, input logic d, input logic dr, input logic wr,
                                         input logic [7:0] data);
    return {20'd0, b, d, dr, wr, data};
  endfunction

  // One frame: byte k = k*mult+add. Cycle 0 is the accepting cycle; outputs are checked 1ns after each negedge.
  task automatic applyStimulus(input int mult, input int add, input int stallAfter, input int stallLen,
                               input int dropCycle, input int resetCycle, input bit scramble);
    int   sent      = 0;
    int   stallUsed = 0;
    int   doneCycle = -1;
    int   writes    = 0;
    bit   hdrDone;
    bit   finished  = 1'b0;
    bit   stall;
    hdrDone = (HDR == 0);
    for (int k = 0; k < NB; k++) expFrame[8*k +: 8] = 8'(k * mult + add);

    @(negedge clock);
    sendData   = expFrame;
    sendSignal = 1'b1;
    tx_full    = 1'b0;
    #1;
    checkOutput("accept_idle", packOut(), expOut(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

    for (int cyc = 1; cyc <= NB + HDR + stallLen + 8 && !finished; cyc++) begin
      @(negedge clock);
      sendSignal = (cyc == dropCycle);
      stall      = (stallAfter >= 0) && hdrDone && (sent == stallAfter + 1) && (stallUsed < stallLen);
      tx_full    = stall;
      if (scramble) begin
        for (int w = 0; w < FW / 32; w++) sendData[32*w +: 32] = $urandom();
      end
      if (cyc == resetCycle) begin
        reset = 1'b1;
        #1;
        checkOutput("async_reset", packOut(), 32'd0);
        @(negedge clock);
        reset      = 1'b0;
        sendSignal = 1'b0;
        tx_full    = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clock);
          #1;
          checkOutput("post_reset_idle", packOut(), 32'd0);
        end
        return;
      end
      #1;
      if (stall) stallUsed++;
      if (!hdrDone) begin
        checkOutput("header", packOut(),
                    expOut(1'b1, 1'b0, sendSignal, !tx_full, tx_full ? 8'h00 : HEADER_BYTE));
        if (!tx_full) begin
          hdrDone = 1'b1;
          writes++;
        end
      end else if (sent < NB) begin
        checkOutput($sformatf("byte%0d", sent), packOut(),
                    expOut(1'b1, 1'b0, sendSignal, !tx_full, expFrame[8*sent +: 8]));
        if (!tx_full) begin
          sent++;
          writes++;
        end
      end else if (doneCycle < 0) begin
        checkOutput("done_pulse", packOut(), expOut(1'b1, 1'b1, sendSignal, 1'b0, 8'h00));
        doneCycle = cyc;
      end else begin
        checkOutput("back_idle", packOut(), expOut(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        finished = 1'b1;
      end
    end

    if (!finished) checkOutput("frame_timeout", 32'd0, 32'd1);
    checkOutput("done_cycle", doneCycle, NB + HDR + 1 + stallLen);
    checkOutput("write_count", writes, NB + HDR);
  endtask

  initial begin
    reset      = 1'b1;
    sendSignal = 1'b0;
    tx_full    = 1'b0;
    sendData   = '0;
    #2;
    checkOutput("reset_state", packOut(), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    $display("[TB] plain frame, byte k = k+1");
    applyStimulus(1, 1, -1, 0, -1, -1, 1'b0);
    $display("[TB] 5-cycle stall after byte 10");
    applyStimulus(1, 1, 10, 5, -1, -1, 1'b0);
    $display("[TB] request during frame at cycle 50");
    applyStimulus(1, 1, -1, 0, 50, -1, 1'b0);
    $display("[TB] sendData changes every cycle after acceptance");
    applyStimulus(3, 7, -1, 0, -1, -1, 1'b1);
    $display("[TB] reset at cycle 100");
    applyStimulus(1, 1, -1, 0, -1, 100, 1'b0);
    $display("[TB] fresh frame after reset");
    applyStimulus(5, 2, -1, 0, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
